// File: rtl/rr_arbiter_param.sv
// Parametrised round-robin arbiter with registered one-hot grant and index.
// Define RR_ARB_LOCK_EN to hold a grant until the owner's last beat or request drop.
module rr_arbiter_param #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] last,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    state_t             state;
    state_t             state_n;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   ptr_n;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   owner_n;
    logic [NUM_REQ-1:0] grant_n;
    logic [IDX_W-1:0]   idx_n;
    logic               valid_n;

    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   pos;
    logic               hit;
    logic               release_ok;
    logic               lock_next;

    // First set request at or above ptr, wrapping modulo NUM_REQ
    always_comb begin
        int j;
        win = '0;
        pos = '0;
        hit = 1'b0;
        j   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            pos = IDX_W'(j);
            if (!hit && req[pos]) begin
                hit = 1'b1;
                win = pos;
            end
        end
    end

`ifdef RR_ARB_LOCK_EN
    assign release_ok = (state == IDLE) || !req[owner] || last[owner];
    assign lock_next  = !last[win];
`else
    logic unused_nolock;
    assign unused_nolock = ^{last, owner};
    assign release_ok    = 1'b1;
    assign lock_next     = 1'b0;
`endif

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        grant_n = grant;
        idx_n   = grant_idx;
        valid_n = grant_valid;
        if (release_ok) begin
            if (!hit) begin
                grant_n = '0;
                idx_n   = '0;
                valid_n = 1'b0;
                state_n = IDLE;
            end else begin
                grant_n = NUM_REQ'(1) << win;
                idx_n   = win;
                valid_n = 1'b1;
                owner_n = win;
                ptr_n   = (win == LAST_IDX) ? '0 : win + IDX_W'(1);
                // A winner already on its last beat gets a single-cycle grant
                state_n = lock_next ? LOCKED : IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            owner       <= owner_n;
            grant       <= grant_n;
            grant_idx   <= idx_n;
            grant_valid <= valid_n;
        end
    end

endmodule

// File: doc/rr_arbiter_param.md
# rr_arbiter_param

Parametrised round-robin arbiter with NUM_REQ requesters. It produces a registered one-hot grant, a binary grant index and a valid flag. It sits in front of shared router/NoC output resources and replaces fixed 4-way arbitration. It adds an idle-clear grant and, optionally, packet-level grant locking.

## Interface
- NUM_REQ, default 4: number of requesters; legal range 1 to 32.
- IDX_W, default $clog2(NUM_REQ), forced to a minimum of 1: width of grant_idx and of the internal pointer.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset. Assertion clears all state immediately; deassertion is synchronous to clk.
- req  input  NUM_REQ  request vector; bit i is requester i. Sampled every rising edge.
- last  input  NUM_REQ  bit i marks the final beat of requester i's packet. Used only when RR_ARB_LOCK_EN is defined; ignored otherwise.
- grant  output  NUM_REQ  registered one-hot grant, or all zero.
- grant_idx  output  IDX_W  binary index of the set grant bit; 0 when grant_valid is 0.
- grant_valid  output  1  high when exactly one grant bit is set.

## Operation
- State: priority pointer ptr (IDX_W bits); owner register (IDX_W bits); FSM with states IDLE and LOCKED (LOCKED is only reachable when the macro is defined).
- Reset values:
  - grant = 0, grant_idx = 0, grant_valid = 0.
  - ptr = 0, owner = 0, FSM = IDLE.
- Arbitration step (runs in IDLE, and in LOCKED when a release condition holds):
  - Scan req starting at index ptr, upward, wrapping modulo NUM_REQ.
  - The first set bit w wins: grant <= onehot(w), grant_idx <= w, grant_valid <= 1, owner <= w.
  - ptr <= w+1, wrapping to 0 when w = NUM_REQ-1.
  - Wrap arithmetic is modulo NUM_REQ, not 2^IDX_W; ptr never holds a value >= NUM_REQ.
- No requests (req = 0): grant <= 0, grant_valid <= 0, grant_idx <= 0; ptr and owner are unchanged; FSM -> IDLE.
- Fairness: a requester that has just won has lowest priority at the next arbitration. With N continuous requesters, each is granted once every N arbitrations.
- NUM_REQ = 1: grant is req delayed by one cycle; grant_idx is held at 0.
- Requests are level-sensitive. The arbiter keeps no memory of a request that was dropped before it was granted.

## Timing
- Latency: a req pattern sampled at edge k appears on grant after edge k. Outputs are flops only, with no combinational path from req to grant.
- Without lock: arbitration occurs every cycle. A continuously requesting set is rotated on every edge, with no bubbles between grants.
- Grant changes only on clock edges or on asynchronous reset.
- Reset mid-operation: all outputs drop to 0 without waiting for a clock edge. The first grant after rst rises is given on the first edge at which req != 0, starting the scan from index 0.

## Configuration
- Macro RR_ARB_LOCK_EN.
- **Defined (packet locking):**
  - After a grant, the FSM enters LOCKED with owner w, and the grant is held for as long as req[w] = 1 and last[w] = 0.
  - At the edge where req[w] = 1 and last[w] = 1 are sampled (final beat), the arbiter re-arbitrates on that same edge. The next packet's grant appears immediately, with zero bubble.
  - At the edge where req[w] = 0 is sampled, the arbiter also re-arbitrates on that same edge. The old owner cannot win, because req[w] = 0.
  - last on non-owner bits is ignored.
  - If last[w] = 1 on the grant-issuing edge itself, that grant lasts exactly one cycle.
- **Undefined:** the last input is ignored, the FSM stays in IDLE, and every edge is an arbitration step.

## Test plan
- **Rotation:** rst pulse, then req = 4'b1111 held, macro off → grant is 0001, 0010, 0100, 1000, 0001 on consecutive edges; grant_idx is 0, 1, 2, 3, 0.
- **Wrap skip:** after grant = 0010 (ptr = 2), drive req = 4'b0011 → next grant is 0001 and ptr becomes 1. Then drive req = 4'b0010 → grant is 0010.
- **Idle and async reset:** with req = 0, grant goes to 0 and grant_valid to 0 at the next edge. With req = 4'b1000, grant is 1000 after one edge. Drop rst mid-cycle → grant = 0 immediately, before the next edge.
- **Lock hold and release (macro on):**
  - req = 4'b1111, last = 0 → grant is held at 0001 for 5 cycles.
  - Pulse last[0] = 1 for one cycle → grant is 0010 at the very next edge.
- **Lock abandon (macro on):** owner 2 drops req[2] while last = 0, and req = 4'b1001 → next grant is 1000, then after release 0001.
- **NUM_REQ = 5:** with ptr = 4 and req = 5'b10001 → grant 10000, then 00001; grant_idx is 4 then 0; ptr never reaches 5.
